// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared fetch/decode definitions: opcode constants, NOP word and fetch FSM state type.
// The immediate extender imports the same opcode set.
package instr_fetch_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic opcode_supported(input logic [6:0] opc);
    case (opc)
      OPC_R, OPC_I_ALU, OPC_LOAD, OPC_STORE,
      OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL: opcode_supported = 1'b1;
      default:                                 opcode_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction memory port, decode handoff and redirect.
interface instr_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_op_known;
  logic        redir_valid;
  logic [31:0] redir_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_op_known,
    input  imem_rvalid, imem_rdata, if_ready, redir_valid, redir_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_op_known,
    output imem_rvalid, imem_rdata, if_ready, redir_valid, redir_pc
  );
endinterface

// File: rtl/instr_fetch_ctrl_opcode_check.sv
// Flags whether the held instruction's opcode belongs to the supported set.
module instr_fetch_ctrl_opcode_check
  import instr_fetch_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       op_known_o
);

  assign op_known_o = opcode_supported(opcode_i);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Single-outstanding instruction fetch controller with redirect/kill handling.
// state  | meaning
// S_REQ  | issue one-cycle imem_req at pc (first cycle after reset only primes the strobe)
// S_WAIT | request outstanding; a kill discards the returning word
// S_HOLD | instruction presented to decode until accepted or redirected
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_ctrl_if.master  bus
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         kill_q;
  logic         imem_req_q;
  logic         if_valid_q;
  logic [31:0]  if_instr_q;
  logic [31:0]  if_pc_q;
  logic [31:0]  redir_target;
  logic         op_known;

  assign redir_target = bus.redir_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      imem_req_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        S_REQ: begin
          if (bus.redir_valid) pc_q <= redir_target;
          if (imem_req_q) begin
            imem_req_q <= 1'b0;
            kill_q     <= bus.redir_valid;
            state_q    <= S_WAIT;
          end else begin
            imem_req_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.redir_valid) pc_q <= redir_target;
          if (bus.imem_rvalid) begin
            kill_q <= 1'b0;
            if (kill_q || bus.redir_valid) begin
              imem_req_q <= 1'b1;
              state_q    <= S_REQ;
            end else begin
              if_instr_q <= bus.imem_rdata;
              if_pc_q    <= pc_q;
              if_valid_q <= 1'b1;
              state_q    <= S_HOLD;
            end
          end else if (bus.redir_valid) begin
            kill_q <= 1'b1;
          end
        end
        S_HOLD: begin
          // Redirect beats a same-cycle accept: the sequential pc+4 is never taken.
          if (bus.redir_valid) begin
            pc_q       <= redir_target;
            if_valid_q <= 1'b0;
            imem_req_q <= 1'b1;
            state_q    <= S_REQ;
          end else if (bus.if_ready) begin
            pc_q       <= pc_q + 32'd4;
            if_valid_q <= 1'b0;
            imem_req_q <= 1'b1;
            state_q    <= S_REQ;
          end
        end
        default: begin
          state_q    <= S_REQ;
          imem_req_q <= 1'b0;
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

  instr_fetch_ctrl_opcode_check u_opcode_check (
    .opcode_i   (if_instr_q[6:0]),
    .op_known_o (op_known)
  );

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_op_known = op_known;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed self-checking bench for instr_fetch_ctrl; memory responses are driven by hand.
module tb_instr_fetch_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word returns in the cycle that is lat cycles after the observed request cycle.
  task automatic respond(input int lat, input logic [31:0] data);
    repeat (lat) tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b valid=%b expected req=0 valid=0", bus.imem_req, bus.if_valid);
    end
    checks++;
    if (bus.if_instr !== 32'h0000_0013 || bus.if_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: instr=%h pc=%h expected instr=00000013 pc=00000000", bus.if_instr, bus.if_pc);
    end
    checks++;
    if (bus.if_op_known !== 1'b1) begin
      errors++;
      $display("FAIL reset_opknown: got %b expected 1", bus.if_op_known);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h expected req=1 addr=00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    logic [31:0] data;
    bus.if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'(4 * k);
      data   = 32'h0000_0033 | (32'(k) << 12);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
        errors++;
        $display("FAIL seq_req[%0d]: req=%b addr=%h expected req=1 addr=%h", k, bus.imem_req, bus.imem_addr, exp_pc);
      end
      tick();
      checks++;
      if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
        errors++;
        $display("FAIL seq_wait[%0d]: req=%b valid=%b expected req=0 valid=0", k, bus.imem_req, bus.if_valid);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = data;
      tick();
      bus.imem_rvalid = 1'b0;
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc || bus.if_instr !== data || bus.if_op_known !== 1'b1) begin
        errors++;
        $display("FAIL seq_hold[%0d]: valid=%b pc=%h instr=%h known=%b expected valid=1 pc=%h instr=%h known=1",
                 k, bus.if_valid, bus.if_pc, bus.if_instr, bus.if_op_known, exp_pc, data);
      end
      tick();
      checks++;
      if (bus.if_valid !== 1'b0) begin
        errors++;
        $display("FAIL seq_drop[%0d]: valid=%b expected 0", k, bus.if_valid);
      end
    end
    bus.if_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    respond(2, 32'h0000_2003);
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hC || bus.if_instr !== 32'h0000_2003) begin
      errors++;
      $display("FAIL stall_enter: valid=%b pc=%h instr=%h expected valid=1 pc=0000000c instr=00002003",
               bus.if_valid, bus.if_pc, bus.if_instr);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0000_007F;
      end
      tick();
      bus.imem_rvalid = 1'b0;
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_instr !== 32'h0000_2003 || bus.if_pc !== 32'hC || bus.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle[%0d]: valid=%b instr=%h pc=%h req=%b expected valid=1 instr=00002003 pc=0000000c req=0",
                 i, bus.if_valid, bus.if_instr, bus.if_pc, bus.imem_req);
      end
    end
    bus.if_ready = 1'b1;
    tick();
    bus.if_ready = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: req=%b addr=%h valid=%b expected req=1 addr=00000010 valid=0",
               bus.imem_req, bus.imem_addr, bus.if_valid);
    end
  endtask

  task automatic test_redirect_wait();
    tick();
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_0103;
    tick();
    bus.redir_valid = 1'b0;
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0000_2003) begin
      errors++;
      $display("FAIL rwait_discard: valid=%b instr=%h expected valid=0 instr=00002003", bus.if_valid, bus.if_instr);
    end
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL rwait_target: req=%b addr=%h expected req=1 addr=00000100", bus.imem_req, bus.imem_addr);
    end
    respond(1, 32'h0000_007F);
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_op_known !== 1'b0) begin
      errors++;
      $display("FAIL rwait_newword: valid=%b pc=%h known=%b expected valid=1 pc=00000100 known=0",
               bus.if_valid, bus.if_pc, bus.if_op_known);
    end
  endtask

  task automatic test_redirect_hold();
    bus.if_ready    = 1'b1;
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_0040;
    tick();
    bus.if_ready    = 1'b0;
    bus.redir_valid = 1'b0;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL rhold: valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000040",
               bus.if_valid, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_redirect_with_rvalid();
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0013;
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_0202;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.redir_valid = 1'b0;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL rboth: valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000200",
               bus.if_valid, bus.imem_req, bus.imem_addr);
    end
    respond(1, 32'h0000_006F);
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h200 || bus.if_instr !== 32'h6F || bus.if_op_known !== 1'b1) begin
      errors++;
      $display("FAIL rboth_next: valid=%b pc=%h instr=%h known=%b expected valid=1 pc=00000200 instr=0000006f known=1",
               bus.if_valid, bus.if_pc, bus.if_instr, bus.if_op_known);
    end
  endtask

  task automatic test_redirect_req();
    bus.if_ready = 1'b1;
    tick();
    bus.if_ready = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h204) begin
      errors++;
      $display("FAIL rreq_issue: req=%b addr=%h expected req=1 addr=00000204", bus.imem_req, bus.imem_addr);
    end
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_0300;
    tick();
    bus.redir_valid = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL rreq_wait: req=%b valid=%b expected req=0 valid=0", bus.imem_req, bus.if_valid);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0033;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) begin
      errors++;
      $display("FAIL rreq_kill: valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000300",
               bus.if_valid, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    respond(1, 32'h0000_0037);
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redir_valid = 1'b0;
    respond(1, 32'h0000_0017);
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_hold: valid=%b pc=%h expected valid=1 pc=fffffffc", bus.if_valid, bus.if_pc);
    end
    bus.if_ready = 1'b1;
    tick();
    bus.if_ready = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: req=%b addr=%h expected req=1 addr=00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_007F;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.if_valid !== 1'b0 || bus.if_instr !== 32'h13) begin
      errors++;
      $display("FAIL rst_wait: req=%b addr=%h valid=%b instr=%h expected req=1 addr=00000000 valid=0 instr=00000013",
               bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_instr);
    end
    respond(1, 32'h0000_0023);
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_instr !== 32'h23 || bus.if_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_refetch: valid=%b instr=%h pc=%h expected valid=1 instr=00000023 pc=00000000",
               bus.if_valid, bus.if_instr, bus.if_pc);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.if_ready    = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = 32'h0;
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_with_rvalid();
    test_redirect_req();
    test_wrap();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
